// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bit indices,
// hold-vector constants and controller state encodings.
package pipe_stall_ctrl_pkg;

  typedef logic [5:0] stall_bus_t;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam stall_bus_t StallNone = 6'b000000;
  localparam stall_bus_t StallId   = 6'b000111;
  localparam stall_bus_t StallEx   = 6'b001111;

  typedef enum logic [1:0] {
    CtrlRun    = 2'd0,
    CtrlMcWait = 2'd1,
    CtrlFlush  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mc_down_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module mc_down_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core.
// Optional stall-cycle perf counter enabled by defining STALL_PERF_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6,
  parameter int STALL_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id_i,
  input  logic                ex_mc_start_i,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles_i,
  input  logic                flush_i,
  output logic [STALL_W-1:0]  stall_o,
  output logic                flush_o,
  output logic                ex_mc_busy_o,
  output logic                ex_mc_done_o,
  output logic [31:0]         stall_cycles_o
);

  ctrl_state_e         state_q;
  ctrl_state_e         state_d;
  stall_bus_t          stall_d;
  logic                flush_d;
  logic                busy_d;
  logic                done_d;
  logic                cnt_load;
  logic [MC_CNT_W-1:0] cnt_load_val;
  logic                cnt_dec;
  logic [MC_CNT_W-1:0] cnt;
  logic                cnt_zero;

  mc_down_counter #(.W(MC_CNT_W)) u_mc_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  // Priority: flush, then multi-cycle op, then decode load-use bubble.
  always_comb begin
    state_d      = state_q;
    stall_d      = StallNone;
    flush_d      = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      CtrlRun: begin
        if (flush_i) begin
          flush_d = 1'b1;
          state_d = CtrlFlush;
        end else if (ex_mc_start_i && (ex_mc_cycles_i >= MC_CNT_W'(2))) begin
          stall_d      = StallEx;
          cnt_load     = 1'b1;
          cnt_load_val = ex_mc_cycles_i - MC_CNT_W'(2);
          state_d      = CtrlMcWait;
        end else if (ex_mc_start_i) begin
          done_d = (ex_mc_cycles_i == MC_CNT_W'(1));
        end else if (stallreq_id_i) begin
          stall_d = StallId;
        end
      end
      CtrlMcWait: begin
        busy_d = 1'b1;
        if (flush_i) begin
          flush_d  = 1'b1;
          cnt_load = 1'b1;
          state_d  = CtrlFlush;
        end else if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = CtrlRun;
        end else begin
          stall_d = StallEx;
          cnt_dec = 1'b1;
        end
      end
      CtrlFlush: begin
        if (flush_i) begin
          flush_d = 1'b1;
          state_d = CtrlFlush;
        end else begin
          state_d = CtrlRun;
        end
      end
      default: begin
        state_d = CtrlRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CtrlRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign stall_o      = rst ? '0 : STALL_W'(stall_d);
  assign flush_o      = rst ? 1'b0 : flush_d;
  assign ex_mc_busy_o = rst ? 1'b0 : busy_d;
  assign ex_mc_done_o = rst ? 1'b0 : done_d;

`ifdef STALL_PERF_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  // Saturating count of cycles in which id/ex is held.
  always_comb begin
    perf_d = perf_q;
    if (stall_o[STALL_ID] && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign stall_cycles_o = rst ? 32'h0 : perf_q;
`else
  assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized self-checking bench for pipe_stall_ctrl against a cycle-count model.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id_i = 1'b0;
  logic        ex_mc_start_i = 1'b0;
  logic [5:0]  ex_mc_cycles_i = '0;
  logic        flush_i = 1'b0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        ex_mc_busy_o;
  logic        ex_mc_done_o;
  logic [31:0] stall_cycles_o;

  int checks = 0;
  int errors = 0;

  // Model: cycles still owed by the current multi-cycle op, whether the
  // previous cycle flushed, and the expected perf count.
  int          mdl_rem = 0;
  bit          mdl_flushing = 1'b0;
  logic [31:0] mdl_perf = '0;

  int obs_ex_stalls = 0;
  int obs_done = 0;
  int obs_flush = 0;

`ifdef STALL_PERF_EN
  localparam logic [31:0] PerfTotalExp = 32'd6;
`else
  localparam logic [31:0] PerfTotalExp = 32'd0;
`endif

  pipe_stall_ctrl #(.MC_CNT_W(6), .STALL_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .ex_mc_start_i  (ex_mc_start_i),
    .ex_mc_cycles_i (ex_mc_cycles_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .ex_mc_busy_o   (ex_mc_busy_o),
    .ex_mc_done_o   (ex_mc_done_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic sreq, input logic start,
                               input logic [5:0] cyc, input logic fl);
    logic [5:0]  e_stall;
    logic        e_flush;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_perf;
    int          n_rem;
    bit          n_fl;
    @(negedge clk);
    rst            = r;
    stallreq_id_i  = sreq;
    ex_mc_start_i  = start;
    ex_mc_cycles_i = cyc;
    flush_i        = fl;
    #1;
    e_stall = 6'h00;
    e_flush = 1'b0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    n_rem   = mdl_rem;
    n_fl    = mdl_flushing;
    if (r) begin
      n_rem = 0;
      n_fl  = 1'b0;
    end else if (mdl_flushing) begin
      e_flush = fl;
      n_fl    = fl;
    end else if (mdl_rem > 0) begin
      e_busy = 1'b1;
      if (fl) begin
        e_flush = 1'b1;
        n_rem   = 0;
        n_fl    = 1'b1;
      end else if (mdl_rem == 1) begin
        e_done = 1'b1;
        n_rem  = 0;
      end else begin
        e_stall = 6'h0F;
        n_rem   = mdl_rem - 1;
      end
    end else if (fl) begin
      e_flush = 1'b1;
      n_fl    = 1'b1;
    end else if (start) begin
      if (cyc >= 6'd2) begin
        e_stall = 6'h0F;
        n_rem   = int'(cyc) - 1;
      end else begin
        e_done = (cyc == 6'd1);
      end
    end else if (sreq) begin
      e_stall = 6'h07;
    end
`ifdef STALL_PERF_EN
    e_perf = r ? 32'h0 : mdl_perf;
`else
    e_perf = 32'h0;
`endif
    checkOutput("stall_o", 32'(stall_o), 32'(e_stall));
    checkOutput("flush_o", 32'(flush_o), 32'(e_flush));
    checkOutput("busy_o", 32'(ex_mc_busy_o), 32'(e_busy));
    checkOutput("done_o", 32'(ex_mc_done_o), 32'(e_done));
    checkOutput("stall_cycles_o", stall_cycles_o, e_perf);
    if (stall_o == 6'h0F) obs_ex_stalls++;
    if (ex_mc_done_o) obs_done++;
    if (flush_o) obs_flush++;
    @(posedge clk);
    mdl_rem      = n_rem;
    mdl_flushing = n_fl;
    if (r) mdl_perf = '0;
    else if (e_stall[2] && (mdl_perf != 32'hFFFF_FFFF)) mdl_perf = mdl_perf + 32'd1;
  endtask

  task automatic clearObs();
    obs_ex_stalls = 0;
    obs_done      = 0;
    obs_flush     = 0;
  endtask

  initial begin
    // Reset with every input high
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd63, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd63, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // Load-use bubble
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    checkOutput("loaduse_stall", 32'(stall_o), 32'h07);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // Five-cycle op: four stalled cycles, one done pulse
    clearObs();
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("mc5_stalls", 32'(obs_ex_stalls), 32'd4);
    checkOutput("mc5_done", 32'(obs_done), 32'd1);

    // Single- and zero-cycle ops
    clearObs();
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("mc1_0_stalls", 32'(obs_ex_stalls), 32'd0);
    checkOutput("mc1_0_done", 32'(obs_done), 32'd1);

    // Longest op
    clearObs();
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd63, 1'b0);
    repeat (64) applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    checkOutput("mc63_stalls", 32'(obs_ex_stalls), 32'd62);
    checkOutput("mc63_done", 32'(obs_done), 32'd1);

    // Flush on the third stalled cycle of a ten-cycle op
    clearObs();
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    checkOutput("abort_stall_after", 32'(stall_o), 32'h07);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("abort_done", 32'(obs_done), 32'd0);
    checkOutput("abort_flush", 32'(obs_flush), 32'd1);

    // Flush beats load-use
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 1'b1);
    checkOutput("flush_vs_id_stall", 32'(stall_o), 32'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // Perf total: one five-cycle op plus two load-use bubbles
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    #1;
    checkOutput("perf_total", stall_cycles_o, PerfTotalExp);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       sreq;
      logic       start;
      logic       fl;
      logic [5:0] cyc;
      r     = ($urandom_range(0, 99) == 0);
      sreq  = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 7) == 0);
      fl    = ($urandom_range(0, 29) == 0);
      cyc   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 2)) : 6'($urandom_range(0, 20));
      applyStimulus(r, sreq, start, cyc, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
